// File: rtl/adt7410_pkg.sv
// adt7410_pkg: shared state encodings and value width for the ADT7410 sensor controller.
package adt7410_pkg;

    localparam int VALUE_WIDTH = 16;

    typedef enum logic [2:0] {
        stDisabled = 3'd0,
        stIdle     = 3'd1,
        stStart    = 3'd2,
        stWaitI2C  = 3'd3,
        stNotify   = 3'd4
    } state_t;

endpackage

// File: rtl/sensor_delta_cmp.sv
// sensor_delta_cmp: |new - old| of two signed words, compared unsigned against a threshold.
module sensor_delta_cmp
    import adt7410_pkg::*;
#(
    parameter int W = VALUE_WIDTH
) (
    input  logic [W-1:0] new_value,
    input  logic [W-1:0] old_value,
    input  logic [W-1:0] threshold,
    output logic         exceeds
);

    logic signed [W:0] diff;
    logic        [W:0] abs_diff;

    // One extra bit keeps the full -65535..+65535 range without overflow.
    always_comb begin
        diff     = $signed({new_value[W-1], new_value}) - $signed({old_value[W-1], old_value});
        abs_diff = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        exceeds  = abs_diff > {1'b0, threshold};
    end

endmodule

// File: rtl/adt7410_sensor_ctrl.sv
// adt7410_sensor_ctrl: periodic one-shot temperature read, reporting and interrupting only on
// changes larger than a programmable threshold.
module adt7410_sensor_ctrl
    import adt7410_pkg::*;
#(
    parameter int WIDTH = VALUE_WIDTH
) (
    input  logic             Clk_i,
    input  logic             Reset_n_i,
    input  logic             Enable_i,
    output logic             CpuIntr_o,
    output logic [WIDTH-1:0] SensorValue_o,
    output logic             I2C_Start_o,
    input  logic             I2C_Done_i,
    input  logic             I2C_Error_i,
    input  logic [7:0]       I2C_Byte0_i,
    input  logic [7:0]       I2C_Byte1_i,
    input  logic [WIDTH-1:0] ParamCounterPreset_i,
    input  logic [WIDTH-1:0] ParamThreshold_i
);

    state_t           state;
    logic [WIDTH-1:0] timer;
    logic [WIDTH-1:0] new_value;
    logic             exceeds;

    assign new_value = {I2C_Byte1_i, I2C_Byte0_i};

    sensor_delta_cmp #(.W(WIDTH)) u_cmp (
        .new_value (new_value),
        .old_value (SensorValue_o),
        .threshold (ParamThreshold_i),
        .exceeds   (exceeds)
    );

    // Outputs are registered alongside the next state so they match a Moore decode of state.
    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            state         <= stDisabled;
            timer         <= '0;
            SensorValue_o <= '0;
            CpuIntr_o     <= 1'b0;
            I2C_Start_o   <= 1'b0;
        end else begin
            timer       <= (state != stIdle) ? ParamCounterPreset_i :
                           (timer != '0) ? timer - WIDTH'(1) : timer;
            CpuIntr_o   <= 1'b0;
            I2C_Start_o <= 1'b0;
            case (state)
                stDisabled: state <= Enable_i ? stIdle : stDisabled;
                stIdle: begin
                    if (!Enable_i) begin
                        state <= stDisabled;
                    end else if (timer == '0) begin
                        state       <= stStart;
                        I2C_Start_o <= 1'b1;
                    end
                end
                stStart: state <= stWaitI2C;
                stWaitI2C: begin
                    if (I2C_Error_i) begin
                        state <= stIdle;
                    end else if (I2C_Done_i && exceeds) begin
                        state         <= stNotify;
                        SensorValue_o <= new_value;
                        CpuIntr_o     <= 1'b1;
                    end else if (I2C_Done_i) begin
                        state <= stIdle;
                    end
                end
                stNotify: state <= stIdle;
                default:  state <= stDisabled;
            endcase
        end
    end

endmodule

// File: tb/tb_adt7410_sensor_ctrl.sv
// tb_adt7410_sensor_ctrl: directed scenario tasks with hand-computed expectations.
module tb_adt7410_sensor_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        intr;
    logic [15:0] value;
    logic        start;
    logic        done;
    logic        err;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] preset;
    logic [15:0] thr;

    int checks = 0;
    int fails  = 0;

    localparam int LIMIT = 40;

    adt7410_sensor_ctrl dut (
        .Clk_i                (clk),
        .Reset_n_i            (rst_n),
        .Enable_i             (enable),
        .CpuIntr_o            (intr),
        .SensorValue_o        (value),
        .I2C_Start_o          (start),
        .I2C_Done_i           (done),
        .I2C_Error_i          (err),
        .I2C_Byte0_i          (b0),
        .I2C_Byte1_i          (b1),
        .ParamCounterPreset_i (preset),
        .ParamThreshold_i     (thr)
    );

    always #5 clk = ~clk;

    // Counts negedges until Start is seen; returns LIMIT if it never appears.
    task automatic wait_start(output int n);
        n = 0;
        while (start !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for Start, answers the transfer, samples the result and the cycle after.
    task automatic measure(input logic [15:0] t, input logic [7:0] hi, input logic [7:0] lo,
                           input logic e, input logic d, output int n, output logic s_after,
                           output logic i1, output logic [15:0] v, output logic i2);
        thr = t;
        wait_start(n);
        @(negedge clk);
        s_after = start;
        b1 = hi; b0 = lo; err = e; done = d;
        @(negedge clk);
        done = 1'b0; err = 1'b0;
        i1 = intr; v = value;
        @(negedge clk);
        i2 = intr;
    endtask

    int n;
    logic sa, i1, i2;
    logic [15:0] v;

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; preset = 16'd3; thr = 16'd5;
        done = 1'b0; err = 1'b0; b0 = 8'h00; b1 = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b want 0", start); end
        checks++; if (intr !== 1'b0) begin fails++; $display("FAIL rst_intr: got %b want 0", intr); end
        checks++; if (value !== 16'h0000) begin fails++; $display("FAIL rst_value: got %h want 0000", value); end
        rst_n = 1'b1;
        // Idle is entered at the first edge after release, Start P+1 cycles later.
        measure(16'd5, 8'h00, 8'h00, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (n !== 5) begin fails++; $display("FAIL first_start_delay: got %0d want 5", n); end
        checks++; if (sa !== 1'b0) begin fails++; $display("FAIL start_one_cycle: got %b want 0", sa); end
        checks++; if (i1 !== 1'b0) begin fails++; $display("FAIL zero_read_intr: got %b want 0", i1); end
        measure(16'd5, 8'h00, 8'h00, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (n !== 3) begin fails++; $display("FAIL period_recur: got %0d want 3", n); end
    endtask

    task automatic test_threshold();
        measure(16'd5, 8'h00, 8'h06, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (n !== 3) begin fails++; $display("FAIL thr6_delay: got %0d want 3", n); end
        checks++; if (i1 !== 1'b1) begin fails++; $display("FAIL thr6_intr: got %b want 1", i1); end
        checks++; if (v !== 16'h0006) begin fails++; $display("FAIL thr6_value: got %h want 0006", v); end
        checks++; if (i2 !== 1'b0) begin fails++; $display("FAIL thr6_intr_pulse: got %b want 0", i2); end
        measure(16'd5, 8'h00, 8'h0B, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (n !== 4) begin fails++; $display("FAIL thr_eq_delay: got %0d want 4", n); end
        checks++; if (i1 !== 1'b0) begin fails++; $display("FAIL thr_eq_intr: got %b want 0", i1); end
        checks++; if (v !== 16'h0006) begin fails++; $display("FAIL thr_eq_value: got %h want 0006", v); end
    endtask

    task automatic test_negative();
        measure(16'd5, 8'h00, 8'h10, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (v !== 16'h0010) begin fails++; $display("FAIL neg_setup: got %h want 0010", v); end
        measure(16'd31, 8'hFF, 8'hF0, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (n !== 4) begin fails++; $display("FAIL neg31_delay: got %0d want 4", n); end
        checks++; if (i1 !== 1'b1) begin fails++; $display("FAIL neg31_intr: got %b want 1", i1); end
        checks++; if (v !== 16'hFFF0) begin fails++; $display("FAIL neg31_value: got %h want fff0", v); end
        measure(16'd0, 8'h00, 8'h10, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (v !== 16'h0010) begin fails++; $display("FAIL neg_restore: got %h want 0010", v); end
        measure(16'd32, 8'hFF, 8'hF0, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (i1 !== 1'b0) begin fails++; $display("FAIL neg32_intr: got %b want 0", i1); end
        checks++; if (v !== 16'h0010) begin fails++; $display("FAIL neg32_value: got %h want 0010", v); end
        measure(16'd0, 8'h7F, 8'hFF, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (n !== 3) begin fails++; $display("FAIL max_delay: got %0d want 3", n); end
        checks++; if (v !== 16'h7FFF) begin fails++; $display("FAIL max_value: got %h want 7fff", v); end
        // 0x7FFF -> 0x8000 is a swing of 65535, just above 0xFFFE.
        measure(16'hFFFE, 8'h80, 8'h00, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (i1 !== 1'b1) begin fails++; $display("FAIL extreme_intr: got %b want 1", i1); end
        checks++; if (v !== 16'h8000) begin fails++; $display("FAIL extreme_value: got %h want 8000", v); end
        measure(16'hFFFF, 8'h7F, 8'hFF, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (i1 !== 1'b0) begin fails++; $display("FAIL thr_max_intr: got %b want 0", i1); end
        checks++; if (v !== 16'h8000) begin fails++; $display("FAIL thr_max_value: got %h want 8000", v); end
    endtask

    task automatic test_error();
        measure(16'd0, 8'h00, 8'h00, 1'b1, 1'b0, n, sa, i1, v, i2);
        checks++; if (n !== 3) begin fails++; $display("FAIL err_delay: got %0d want 3", n); end
        checks++; if (i1 !== 1'b0) begin fails++; $display("FAIL err_intr: got %b want 0", i1); end
        checks++; if (v !== 16'h8000) begin fails++; $display("FAIL err_value: got %h want 8000", v); end
        measure(16'd0, 8'h81, 8'h00, 1'b1, 1'b1, n, sa, i1, v, i2);
        checks++; if (n !== 3) begin fails++; $display("FAIL err_done_delay: got %0d want 3", n); end
        checks++; if (i1 !== 1'b0) begin fails++; $display("FAIL err_done_intr: got %b want 0", i1); end
        checks++; if (v !== 16'h8000) begin fails++; $display("FAIL err_done_value: got %h want 8000", v); end
        measure(16'd0, 8'h80, 8'h00, 1'b0, 1'b1, n, sa, i1, v, i2);
        checks++; if (n !== 3) begin fails++; $display("FAIL err_next_start: got %0d want 3", n); end
    endtask

    task automatic test_enable_drop();
        thr = 16'd0;
        wait_start(n);
        checks++; if (n !== 3) begin fails++; $display("FAIL dis_start: got %0d want 3", n); end
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (start !== 1'b0 || intr !== 1'b0) begin fails++; $display("FAIL dis_waiting: got start=%b intr=%b want 0 0", start, intr); end
        b1 = 8'h12; b0 = 8'h34; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        checks++; if (intr !== 1'b1) begin fails++; $display("FAIL dis_intr: got %b want 1", intr); end
        checks++; if (value !== 16'h1234) begin fails++; $display("FAIL dis_value: got %h want 1234", value); end
        @(negedge clk);
        wait_start(n);
        checks++; if (n !== LIMIT) begin fails++; $display("FAIL dis_no_start: got %0d want %0d", n, LIMIT); end
        enable = 1'b1;
        wait_start(n);
        checks++; if (n !== 5) begin fails++; $display("FAIL reenable_delay: got %0d want 5", n); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        checks++; if (start !== 1'b0) begin fails++; $display("FAIL mid_in_wait: got %b want 0", start); end
        rst_n = 1'b0; enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (value !== 16'h0000) begin fails++; $display("FAIL mid_rst_value: got %h want 0000", value); end
        b1 = 8'h55; b0 = 8'hAA; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        checks++; if (intr !== 1'b0) begin fails++; $display("FAIL late_done_intr: got %b want 0", intr); end
        checks++; if (value !== 16'h0000) begin fails++; $display("FAIL late_done_value: got %h want 0000", value); end
        wait_start(n);
        checks++; if (n !== LIMIT) begin fails++; $display("FAIL mid_disabled: got %0d want %0d", n, LIMIT); end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_negative();
        test_error();
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adt7410_sensor_ctrl.md
Name: adt7410_sensor_ctrl

Overview:
- Application controller directly upstream of the ADT7410 I2C transfer FSM.
- Periodically triggers a one-shot temperature read, waits for Done/Error, then consumes the two result bytes.
- Raises a one-cycle CPU interrupt and updates the reported value only when the new reading differs from the last reported reading by more than a programmable threshold.

Parameters:
- WIDTH, 16, width of the sensor value, threshold and period counter. Fixed at 16 for this application; no other value is supported.

Ports:
- Clk_i  in  1  system clock; all state changes on its rising edge.
- Reset_n_i  in  1  reset, synchronous, active low.
- Enable_i  in  1  application enable.
- CpuIntr_o  out  1  one-cycle pulse when SensorValue_o has been updated.
- SensorValue_o  out  16  last reported temperature word {Byte1, Byte0}, two's complement.
- I2C_Start_o  out  1  one-cycle start pulse to the I2C transfer FSM.
- I2C_Done_i  in  1  transfer FSM finished; bytes valid in this cycle.
- I2C_Error_i  in  1  transfer FSM aborted on an I2C error.
- I2C_Byte0_i  in  8  temperature LSB byte.
- I2C_Byte1_i  in  8  temperature MSB byte.
- ParamCounterPreset_i  in  16  measurement period preset, in cycles.
- ParamThreshold_i  in  16  unsigned change threshold.

Behaviour:
- Reset (synchronous, Reset_n_i=0 at a rising edge):
  - state=stDisabled, Timer=0, SensorValue_o=0, CpuIntr_o=0, I2C_Start_o=0.
  - Reset mid-transfer simply abandons the transfer; a subsequent late Done is ignored because the FSM is in stDisabled.
- Outputs are Moore decodes of the state register:
  - I2C_Start_o=1 only in stStart.
  - CpuIntr_o=1 only in stNotify.
- Timer:
  - Loads ParamCounterPreset_i in every cycle the state is not stIdle.
  - In stIdle it decrements by 1 per cycle while nonzero.
- stDisabled:
  - Enable_i=1 -> stIdle; otherwise stay.
- stIdle:
  - Enable_i=0 -> stDisabled (takes priority over the timer).
  - Else if Timer==0 -> stStart; else stay.
  - With preset P, stStart is entered P+1 cycles after entering stIdle. P=0 gives a 1-cycle idle.
- stStart:
  - I2C_Start_o=1 for exactly one cycle; -> stWaitI2C unconditionally.
- stWaitI2C:
  - I2C_Error_i=1 -> stIdle. No update, no interrupt. Error has priority if Done is high in the same cycle.
  - Else if I2C_Done_i=1:
    - New = {I2C_Byte1_i, I2C_Byte0_i}.
    - Diff = sign-extended New minus sign-extended SensorValue_o, 17-bit signed.
    - AbsDiff = |Diff|, 17-bit unsigned.
    - If AbsDiff > {1'b0, ParamThreshold_i} (strictly greater): SensorValue_o<=New at this edge, -> stNotify.
    - Else -> stIdle with SensorValue_o unchanged.
  - Enable_i is ignored in this state; an I2C transfer is never aborted. The disable takes effect in the next stIdle cycle.
  - Otherwise stay; there is no timeout.
- stNotify:
  - CpuIntr_o=1 for one cycle; SensorValue_o already holds New. -> stIdle.
- Extremes:
  - Diff range is -65535..+65535. 0x7FFF vs 0x8000 gives AbsDiff=65535 with no overflow.
  - Threshold 0xFFFF therefore never fires.
- The first measurement after reset compares against 0.
- Unused state encodings -> stDisabled.

Decomposition:
- Shared package adt7410_pkg holds:
  - state encodings (stDisabled, stIdle, stStart, stWaitI2C, stNotify; 3 bits);
  - the value width constant (16).
- One sub-module, sensor_delta_cmp: combinational signed 16-bit absolute difference plus unsigned compare against the threshold. Inputs New, Old, Threshold; output Exceeds. Instantiated once.
- Timer and FSM stay in the top.

Test Plan:
- Reset, Enable_i=1, P=3: I2C_Start_o rises exactly 4 cycles after entering stIdle, lasts 1 cycle, recurs each period. Outputs are 0 during and after reset.
- Threshold=5, stored 0x0000; Done with bytes 0x00/0x06 -> SensorValue_o=0x0006 and CpuIntr_o 1-cycle pulse. Then Done with 0x00/0x0B (diff exactly 5) -> no update, no pulse.
- Negative values: stored 0x0010, Done with 0xFF/0xF0 (-16), Threshold=31 -> fires (AbsDiff 32). Repeat with Threshold=32 -> no fire. Also 0x7FFF vs 0x8000 with Threshold=0xFFFE -> fires.
- I2C_Error_i in stWaitI2C, alone and simultaneously with Done and bytes differing by 0x100 -> value unchanged, no interrupt, next Start after P+1 idle cycles.
- Enable_i dropped during stWaitI2C: FSM waits for Done, processes and reports normally, then enters stDisabled with no further Start pulses. Re-enable restarts the period from P.
- Reset_n_i asserted for one cycle while in stWaitI2C: next state stDisabled, SensorValue_o=0; a Done pulse arriving afterwards is ignored.
